// File: rtl/_ram8_pkg.sv
// Shared widths and types for the 8-word x 16-bit RAM slice.
// All buses are MSB-first: bit 0 is the most significant bit, for both data and address.
`timescale 1ns/1ps
package _ram8_pkg;
   localparam int unsigned WORD_W = 16;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned WORDS  = 1 << ADDR_W;

   typedef logic [0:WORD_W-1] word_t;
   typedef logic [0:ADDR_W-1] addr_t;
endpackage

// File: rtl/_ram8_gates.sv
// Gate-level building blocks for _ram8: storage bit/register, load demultiplexers, read multiplexers.
// Select bit 0 is always the MSB and is the first split in every tree.
`timescale 1ns/1ps

module _bit (
   input  logic in_clk,
   input  logic in_rst_n,
   input  logic in_d,
   input  logic in_load,
   output logic out_q
);
   logic bit_d;
   logic bit_q;

   always_comb begin
      bit_d = in_load ? in_d : bit_q;
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) bit_q <= 1'b0;
      else           bit_q <= bit_d;
   end

   assign out_q = bit_q;
endmodule

module _register16
   import _ram8_pkg::*;
#(
   parameter int unsigned N = WORD_W
) (
   input  logic         in_clk,
   input  logic         in_rst_n,
   input  logic [0:N-1] in_a,
   input  logic         in_load,
   output logic [0:N-1] out_y
);
   for (genvar i = 0; i < N; i++) begin : g_bit
      _bit u_bit (
         .in_clk  (in_clk),
         .in_rst_n(in_rst_n),
         .in_d    (in_a[i]),
         .in_load (in_load),
         .out_q   (out_y[i])
      );
   end
endmodule

module _dmux (
   input  logic in_x,
   input  logic in_sel,
   output logic out_a,
   output logic out_b
);
   assign out_a = in_x & ~in_sel;
   assign out_b = in_x &  in_sel;
endmodule

module _dmux4way (
   input  logic       in_x,
   input  logic [0:1] in_sel,
   output logic [0:3] out_y
);
   logic lo;
   logic hi;

   _dmux u_top (.in_x(in_x), .in_sel(in_sel[0]), .out_a(lo),       .out_b(hi));
   _dmux u_lo  (.in_x(lo),   .in_sel(in_sel[1]), .out_a(out_y[0]), .out_b(out_y[1]));
   _dmux u_hi  (.in_x(hi),   .in_sel(in_sel[1]), .out_a(out_y[2]), .out_b(out_y[3]));
endmodule

module _dmux8way (
   input  logic       in_x,
   input  logic [0:2] in_sel,
   output logic [0:7] out_y
);
   logic lo;
   logic hi;

   // MSB picks the half, the remaining two bits pick the word within it
   _dmux     u_top (.in_x(in_x), .in_sel(in_sel[0]),   .out_a(lo), .out_b(hi));
   _dmux4way u_lo  (.in_x(lo),   .in_sel(in_sel[1:2]), .out_y(out_y[0:3]));
   _dmux4way u_hi  (.in_x(hi),   .in_sel(in_sel[1:2]), .out_y(out_y[4:7]));
endmodule

module _mux16
   import _ram8_pkg::*;
#(
   parameter int unsigned N = WORD_W
) (
   input  logic [0:N-1] in_a,
   input  logic [0:N-1] in_b,
   input  logic         in_sel,
   output logic [0:N-1] out_y
);
   assign out_y = in_sel ? in_b : in_a;
endmodule

module _mux4way16
   import _ram8_pkg::*;
#(
   parameter int unsigned N = WORD_W
) (
   input  logic [0:N-1] in_w0,
   input  logic [0:N-1] in_w1,
   input  logic [0:N-1] in_w2,
   input  logic [0:N-1] in_w3,
   input  logic [0:1]   in_sel,
   output logic [0:N-1] out_y
);
   logic [0:N-1] lo;
   logic [0:N-1] hi;

   _mux16 #(.N(N)) u_lo  (.in_a(in_w0), .in_b(in_w1), .in_sel(in_sel[1]), .out_y(lo));
   _mux16 #(.N(N)) u_hi  (.in_a(in_w2), .in_b(in_w3), .in_sel(in_sel[1]), .out_y(hi));
   _mux16 #(.N(N)) u_top (.in_a(lo),    .in_b(hi),    .in_sel(in_sel[0]), .out_y(out_y));
endmodule

module _mux8way16
   import _ram8_pkg::*;
#(
   parameter int unsigned N = WORD_W
) (
   input  logic [0:N-1] in_w [8],
   input  logic [0:2]   in_sel,
   output logic [0:N-1] out_y
);
   logic [0:N-1] lo;
   logic [0:N-1] hi;

   _mux4way16 #(.N(N)) u_lo (
      .in_w0(in_w[0]), .in_w1(in_w[1]), .in_w2(in_w[2]), .in_w3(in_w[3]),
      .in_sel(in_sel[1:2]), .out_y(lo)
   );
   _mux4way16 #(.N(N)) u_hi (
      .in_w0(in_w[4]), .in_w1(in_w[5]), .in_w2(in_w[6]), .in_w3(in_w[7]),
      .in_sel(in_sel[1:2]), .out_y(hi)
   );
   _mux16 #(.N(N)) u_top (.in_a(lo), .in_b(hi), .in_sel(in_sel[0]), .out_y(out_y));
endmodule

// File: rtl/_ram8.sv
// Eight-word x 16-bit RAM: one load strobe steered to a single register, combinational read mux.
// Reads have zero latency; a write becomes visible on out_y after the loading edge.
`timescale 1ns/1ps
module _ram8
   import _ram8_pkg::*;
#(
   parameter int unsigned N     = WORD_W,
   parameter int unsigned DEPTH = WORDS
) (
   input  logic              in_clk,
   input  logic              in_rst_n,
   input  logic [0:N-1]      in_a,
   input  logic              in_load,
   input  logic [0:ADDR_W-1] in_addr,
   output logic [0:N-1]      out_y
);
   logic [0:DEPTH-1] load_sel;
   logic [0:N-1]     word_y [8];

   _dmux8way u_dmux (
      .in_x  (in_load),
      .in_sel(in_addr),
      .out_y (load_sel)
   );

   for (genvar k = 0; k < DEPTH; k++) begin : g_word
      _register16 #(.N(N)) u_reg (
         .in_clk  (in_clk),
         .in_rst_n(in_rst_n),
         .in_a    (in_a),
         .in_load (load_sel[k]),
         .out_y   (word_y[k])
      );
   end

   _mux8way16 #(.N(N)) u_mux (
      .in_w  (word_y),
      .in_sel(in_addr),
      .out_y (out_y)
   );
endmodule

// File: tb/tb__ram8.sv
// Self-checking bench for _ram8 against a plain array model of the eight words.
`timescale 1ns/1ps
module tb__ram8;
   logic        in_clk;
   logic        in_rst_n;
   logic [0:15] in_a;
   logic        in_load;
   logic [0:2]  in_addr;
   logic [0:15] out_y;

   int checks;
   int failures;
   logic [15:0] mem [8];

   _ram8 dut (
      .in_clk  (in_clk),
      .in_rst_n(in_rst_n),
      .in_a    (in_a),
      .in_load (in_load),
      .in_addr (in_addr),
      .out_y   (out_y)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   // Drive one cycle at the falling edge; update the model at the rising edge.
   task automatic drive_cycle(input logic [2:0] addr, input logic [15:0] data, input logic ld);
      @(negedge in_clk);
      in_addr = addr;
      in_a    = data;
      in_load = ld;
      @(posedge in_clk);
      if (ld && in_rst_n) mem[addr] = data;
      #1;
   endtask

   task automatic test_reset;
      in_rst_n = 1'b0;
      in_load  = 1'b1;
      in_a     = 16'hFFFF;
      in_addr  = 3'd5;
      for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
      repeat (3) @(posedge in_clk);
      @(negedge in_clk);
      for (int k = 0; k < 8; k++) begin
         in_addr = k[2:0];
         #1;
         checks++;
         if (out_y !== 16'h0000) begin
            failures++;
            $display("FAIL reset_word addr=%0d got=%h want=0000", k, out_y);
         end
      end
      in_load = 1'b0;
      @(negedge in_clk);
      in_rst_n = 1'b1;
   endtask

   task automatic test_fill;
      for (int k = 0; k < 8; k++) drive_cycle(k[2:0], 16'h1110 + k[15:0], 1'b1);
      in_load = 1'b0;
      for (int k = 0; k < 8; k++) begin
         in_addr = k[2:0];
         #1;
         checks++;
         if (out_y !== 16'h1110 + k[15:0]) begin
            failures++;
            $display("FAIL fill_readback addr=%0d got=%h want=%h", k, out_y, 16'h1110 + k[15:0]);
         end
      end
   endtask

   task automatic test_read_during_write;
      @(negedge in_clk);
      in_addr = 3'd2;
      in_a    = 16'hBEEF;
      in_load = 1'b1;
      #1;
      checks++;
      if (out_y !== 16'h1112) begin
         failures++;
         $display("FAIL rdw_before_edge got=%h want=1112", out_y);
      end
      @(posedge in_clk);
      mem[2] = 16'hBEEF;
      #1;
      in_load = 1'b0;
      checks++;
      if (out_y !== 16'hBEEF) begin
         failures++;
         $display("FAIL rdw_after_edge got=%h want=beef", out_y);
      end
      for (int k = 0; k < 8; k++) begin
         in_addr = k[2:0];
         #1;
         checks++;
         if (out_y !== mem[k]) begin
            failures++;
            $display("FAIL rdw_others addr=%0d got=%h want=%h", k, out_y, mem[k]);
         end
      end
   endtask

   task automatic test_load_low;
      for (int i = 0; i < 8; i++) drive_cycle(i[2:0], 16'hDEAD, 1'b0);
      for (int k = 0; k < 8; k++) begin
         in_addr = k[2:0];
         #1;
         checks++;
         if (out_y !== mem[k]) begin
            failures++;
            $display("FAIL load_low_hold addr=%0d got=%h want=%h", k, out_y, mem[k]);
         end
      end
   endtask

   task automatic test_async_reset;
      @(negedge in_clk);
      in_addr = 3'd4;
      in_load = 1'b1;
      in_a    = 16'h7777;
      #1;
      in_load = 1'b0;
      #1;
      in_rst_n = 1'b0;
      #1;
      checks++;
      if (out_y !== 16'h0000) begin
         failures++;
         $display("FAIL async_reset_immediate got=%h want=0000", out_y);
      end
      #2;
      in_rst_n = 1'b1;
      for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
      for (int k = 0; k < 8; k++) begin
         in_addr = k[2:0];
         #0.1;
         checks++;
         if (out_y !== 16'h0000) begin
            failures++;
            $display("FAIL async_reset_cleared addr=%0d got=%h want=0000", k, out_y);
         end
      end
   endtask

   task automatic test_back_to_back;
      drive_cycle(3'd6, 16'h6666, 1'b1);
      drive_cycle(3'd7, 16'hAAAA, 1'b1);
      drive_cycle(3'd7, 16'h5555, 1'b1);
      in_load = 1'b0;
      in_addr = 3'd7;
      #1;
      checks++;
      if (out_y !== 16'h5555) begin
         failures++;
         $display("FAIL b2b_last_wins got=%h want=5555", out_y);
      end
      in_addr = 3'd6;
      #1;
      checks++;
      if (out_y !== 16'h6666) begin
         failures++;
         $display("FAIL b2b_neighbour got=%h want=6666", out_y);
      end
   endtask

   task automatic test_random;
      logic [2:0]  ra;
      logic [15:0] rd;
      logic        rl;
      for (int i = 0; i < 300; i++) begin
         ra = 3'($urandom_range(0, 7));
         rd = 16'($urandom);
         rl = 1'($urandom_range(0, 1));
         @(negedge in_clk);
         in_addr = ra;
         in_a    = rd;
         in_load = rl;
         #1;
         checks++;
         if (out_y !== mem[ra]) begin
            failures++;
            $display("FAIL random_pre_edge i=%0d addr=%0d got=%h want=%h", i, ra, out_y, mem[ra]);
         end
         @(posedge in_clk);
         if (rl) mem[ra] = rd;
         #1;
         in_addr = 3'($urandom_range(0, 7));
         #1;
         checks++;
         if (out_y !== mem[in_addr]) begin
            failures++;
            $display("FAIL random_post_edge i=%0d addr=%0d got=%h want=%h", i, in_addr, out_y, mem[in_addr]);
         end
      end
      in_load = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      in_rst_n = 1'b0;
      in_load  = 1'b0;
      in_a     = 16'h0000;
      in_addr  = 3'd0;
      test_reset();
      test_fill();
      test_read_during_write();
      test_load_low();
      test_async_reset();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
